// File: rtl/rf_chk_pkg.sv
// Shared definitions for the register-file result checker: FSM state
// encoding and the bit layout of a queued expectation entry.
// Entry layout, LSB first: value, register index, [mask], last flag.
// The mask field exists only when RF_CHK_MASK_EN is defined.
package rf_chk_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_PASS = 3'd3;
    localparam logic [2:0] ST_FAIL = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_WAIT = ST_WAIT,
        S_PASS = ST_PASS,
        S_FAIL = ST_FAIL,
        S_DONE = ST_DONE
    } state_e;

    // Expected value always sits at the bottom of the entry.
    localparam int FLD_VALUE_LSB = 0;

    // Register index follows the expected value.
    function automatic int fld_reg_lsb(input int dwidth);
        return dwidth;
    endfunction

    // Optional compare mask follows the register index.
    function automatic int fld_mask_lsb(input int dwidth, input int ridx_w);
        return dwidth + ridx_w;
    endfunction

    // The last flag is the top bit of the entry.
    function automatic int fld_last_bit(input int dwidth, input int ridx_w, input int mask_en);
        return dwidth + ridx_w + ((mask_en != 0) ? dwidth : 0);
    endfunction

endpackage

// File: rtl/rf_chk_fifo.sv
// Small synchronous FIFO holding queued expectations.
// full/empty are registered flags; a push while full is dropped even if a
// pop happens in the same cycle. DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally.
module rf_chk_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full_q;
    logic             empty_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push_i && !full_q;
    assign pop_ok_s  = pop_i && !empty_q;

    // Next occupancy from the accepted push/pop combination.
    always_comb begin
        count_d = count_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and registered occupancy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_FULL);
            empty_q <= (count_d == '0);
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/rf_result_checker.sv
// Register-file result checker: queues {register, expected value} checks and
// compares each against a flattened register snapshot with a per-check
// cycle timeout. Reports a pass pulse per check, a sticky fail with
// diagnostics, and an all-passed flag once the last-marked check passes.
// Optional build macro RF_CHK_MASK_EN adds a per-entry compare mask
// (exp_mask); without it a full-width equality compare is used.
module rf_result_checker
    import rf_chk_pkg::*;
#(
    parameter int  DWIDTH  = 16,
    parameter int  NREGS   = 4,
    localparam int RIDX_W  = $clog2(NREGS),
    parameter int  TIMEOUT = 100,
    parameter int  QDEPTH  = 4,
    parameter int  CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_in,
    input  logic [NREGS*DWIDTH-1:0] rf_flat,
    input  logic                    exp_valid,
    output logic                    exp_ready,
    input  logic [RIDX_W-1:0]       exp_reg,
    input  logic [DWIDTH-1:0]       exp_value,
    input  logic                    exp_last,
`ifdef RF_CHK_MASK_EN
    input  logic [DWIDTH-1:0]       exp_mask,
`endif
    output logic                    pass_pulse,
    output logic                    fail,
    output logic                    fail_timeout,
    output logic [CNT_W-1:0]        test_id,
    output logic [DWIDTH-1:0]       got_value,
    output logic [CNT_W-1:0]        wait_cycles,
    output logic                    all_passed
);

`ifdef RF_CHK_MASK_EN
    localparam int MASK_EN  = 1;
    localparam int MASK_LSB = fld_mask_lsb(DWIDTH, RIDX_W);
`else
    localparam int MASK_EN  = 0;
`endif
    localparam int REG_LSB  = fld_reg_lsb(DWIDTH);
    localparam int LAST_BIT = fld_last_bit(DWIDTH, RIDX_W, MASK_EN);
    localparam int ENTRY_W  = LAST_BIT + 1;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    // FIFO interface
    logic [ENTRY_W-1:0] entry_in_s;
    logic [ENTRY_W-1:0] fifo_rdata_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               pop_s;

    // Current test
    state_e             state_q;
    logic [ENTRY_W-1:0] entry_q;
    logic [DWIDTH-1:0]  exp_val_s;
    logic [RIDX_W-1:0]  exp_reg_s;
    logic               exp_last_s;
    logic [DWIDTH-1:0]  cmp_val_s;
    logic               idx_ok_s;
    logic               match_s;

    // Registered outputs
    logic               pass_pulse_q;
    logic               fail_q;
    logic               fail_timeout_q;
    logic [CNT_W-1:0]   test_id_q;
    logic [DWIDTH-1:0]  got_value_q;
    logic [CNT_W-1:0]   wait_cycles_q;
    logic               all_passed_q;

    // Pack the offered expectation into a queue entry.
    always_comb begin
        entry_in_s = '0;
        entry_in_s[FLD_VALUE_LSB +: DWIDTH] = exp_value;
        entry_in_s[REG_LSB +: RIDX_W]       = exp_reg;
`ifdef RF_CHK_MASK_EN
        entry_in_s[MASK_LSB +: DWIDTH]      = exp_mask;
`endif
        entry_in_s[LAST_BIT]                = exp_last;
    end

    // Pop only when idle; FAIL and DONE leave the queue filling up untouched.
    assign pop_s = (state_q == S_IDLE) && !fifo_empty_s;

    rf_chk_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (exp_valid),
        .wr_data_i (entry_in_s),
        .pop_i     (pop_s),
        .rd_data_o (fifo_rdata_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s)
    );

    assign exp_ready = !fifo_full_s;

    assign exp_val_s  = entry_q[FLD_VALUE_LSB +: DWIDTH];
    assign exp_reg_s  = entry_q[REG_LSB +: RIDX_W];
    assign exp_last_s = entry_q[LAST_BIT];

    // One-hot select of the watched register; an out-of-range index reads 0.
    always_comb begin
        cmp_val_s = '0;
        idx_ok_s  = 1'b0;
        for (int k = 0; k < NREGS; k++) begin
            cmp_val_s = cmp_val_s |
                        ({DWIDTH{int'(exp_reg_s) == k}} & rf_flat[k*DWIDTH +: DWIDTH]);
            idx_ok_s  = idx_ok_s | (int'(exp_reg_s) == k);
        end
    end

`ifdef RF_CHK_MASK_EN
    assign match_s = (((cmp_val_s ^ exp_val_s) & entry_q[MASK_LSB +: DWIDTH]) == '0);
`else
    assign match_s = (cmp_val_s == exp_val_s);
`endif

    // Check sequencer with its registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            entry_q        <= '0;
            pass_pulse_q   <= 1'b0;
            fail_q         <= 1'b0;
            fail_timeout_q <= 1'b0;
            test_id_q      <= '0;
            got_value_q    <= '0;
            wait_cycles_q  <= '0;
            all_passed_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty_s) begin
                        entry_q <= fifo_rdata_s;
                        if (test_id_q != CNT_MAX) begin
                            test_id_q <= test_id_q + CNT_ONE;
                        end
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    wait_cycles_q <= '0;
                    state_q       <= S_WAIT;
                end
                S_WAIT: begin
                    if (en_in) begin
                        got_value_q <= cmp_val_s;
                        if (!idx_ok_s) begin
                            fail_q         <= 1'b1;
                            fail_timeout_q <= 1'b0;
                            state_q        <= S_FAIL;
                        end else if (match_s) begin
                            pass_pulse_q <= 1'b1;
                            state_q      <= S_PASS;
                        end else if (wait_cycles_q == TO_LAST) begin
                            fail_q         <= 1'b1;
                            fail_timeout_q <= 1'b1;
                            state_q        <= S_FAIL;
                        end else if (wait_cycles_q != CNT_MAX) begin
                            wait_cycles_q <= wait_cycles_q + CNT_ONE;
                        end
                    end
                end
                S_PASS: begin
                    pass_pulse_q <= 1'b0;
                    if (exp_last_s) begin
                        all_passed_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_FAIL: begin
                    state_q <= S_FAIL;
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pass_pulse   = pass_pulse_q;
    assign fail         = fail_q;
    assign fail_timeout = fail_timeout_q;
    assign test_id      = test_id_q;
    assign got_value    = got_value_q;
    assign wait_cycles  = wait_cycles_q;
    assign all_passed   = all_passed_q;

endmodule

// File: tb/tb_rf_result_checker.sv
// Self-checking bench for rf_result_checker (3 watched registers so an
// out-of-range index is reachable, TIMEOUT=10, QDEPTH=4).
module tb_rf_result_checker;

    localparam int DW = 16;
    localparam int NR = 3;
    localparam int RW = $clog2(NR);
    localparam int TO = 10;
    localparam int QD = 4;
    localparam int CW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en_in;
    logic [NR*DW-1:0] rf_flat;
    logic            exp_valid;
    logic            exp_ready;
    logic [RW-1:0]   exp_reg;
    logic [DW-1:0]   exp_value;
    logic            exp_last;
`ifdef RF_CHK_MASK_EN
    logic [DW-1:0]   exp_mask;
`endif
    logic            pass_pulse;
    logic            fail;
    logic            fail_timeout;
    logic [CW-1:0]   test_id;
    logic [DW-1:0]   got_value;
    logic [CW-1:0]   wait_cycles;
    logic            all_passed;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_total = 0;

    rf_result_checker #(
        .DWIDTH (DW), .NREGS (NR), .TIMEOUT (TO), .QDEPTH (QD), .CNT_W (CW)
    ) dut (
        .clk (clk), .rst_n (rst_n), .en_in (en_in), .rf_flat (rf_flat),
        .exp_valid (exp_valid), .exp_ready (exp_ready), .exp_reg (exp_reg),
        .exp_value (exp_value), .exp_last (exp_last),
`ifdef RF_CHK_MASK_EN
        .exp_mask (exp_mask),
`endif
        .pass_pulse (pass_pulse), .fail (fail), .fail_timeout (fail_timeout),
        .test_id (test_id), .got_value (got_value), .wait_cycles (wait_cycles),
        .all_passed (all_passed)
    );

    always #5 clk = ~clk;

    // Count every pass pulse, sampled away from the active edge.
    always @(negedge clk) if (pass_pulse) pulse_total++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running required done");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input int k, input logic [DW-1:0] v);
        rf_flat[k*DW +: DW] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en_in = 1'b1;
        exp_valid = 1'b0;
        exp_reg = '0;
        exp_value = '0;
        exp_last = 1'b0;
`ifdef RF_CHK_MASK_EN
        exp_mask = '1;
`endif
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Offer one entry and hold it until accepted (bounded).
    task automatic push(input int r, input logic [DW-1:0] v, input logic last, output bit ok);
        exp_valid = 1'b1;
        exp_reg   = RW'(r);
        exp_value = v;
        exp_last  = last;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (exp_ready) ok = 1'b1;
            tick();
        end
        exp_valid = 1'b0;
        if (!ok) chk("push_accept", 64'd0, 64'd1);
    endtask

    // Wait for pass or fail after a push; optionally change reg r at tick set_t.
    task automatic run_test(input int set_t, input int r, input logic [DW-1:0] v,
                            output int cyc, output bit saw_pass, output bit saw_fail);
        cyc = 0; saw_pass = 1'b0; saw_fail = 1'b0;
        for (int t = 1; t <= 40 && !saw_pass && !saw_fail; t++) begin
            tick();
            cyc = t;
            if (pass_pulse) saw_pass = 1'b1;
            if (fail) saw_fail = 1'b1;
            if (t == set_t && r < NR) set_reg(r, v);
        end
        if (!saw_pass && !saw_fail) chk("outcome_bound", 64'd0, 64'd1);
    endtask

    typedef struct {
        int          r;
        logic [15:0] val;
        logic [15:0] rf;
        bit          exp_pass;
        bit          exp_to;
        logic [15:0] exp_got;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit ok, sp, sf;
        int cyc, p0;
        int r, k, exp_cyc, exp_wc;
        logic [DW-1:0] v, bg, exp_got;
        bit exp_pass, exp_to;

        vecs[0] = '{2, 16'h0004, 16'h0004, 1'b1, 1'b0, 16'h0004, 3};
        vecs[1] = '{0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 3};
        vecs[2] = '{1, 16'h0007, 16'h0003, 1'b0, 1'b1, 16'h0003, 12};
        vecs[3] = '{0, 16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 12};
        vecs[4] = '{3, 16'h1234, 16'h1234, 1'b0, 1'b0, 16'h0000, 3};
        vecs[5] = '{1, 16'hA5A5, 16'hA5A4, 1'b0, 1'b1, 16'hA5A4, 12};

        rf_flat = '0;
        do_reset();

        // Reset state
        chk("rst_ready", exp_ready, 1);
        chk("rst_pass", pass_pulse, 0);
        chk("rst_fail", fail, 0);
        chk("rst_fail_to", fail_timeout, 0);
        chk("rst_test_id", test_id, 0);
        chk("rst_got", got_value, 0);
        chk("rst_wait", wait_cycles, 0);
        chk("rst_all", all_passed, 0);

        // Table-driven single checks with a constant register file
        for (int i = 0; i < 6; i++) begin
            do_reset();
            for (int j = 0; j < NR; j++) set_reg(j, ~vecs[i].rf);
            if (vecs[i].r < NR) set_reg(vecs[i].r, vecs[i].rf);
            push(vecs[i].r, vecs[i].val, 1'b1, ok);
            run_test(0, 0, '0, cyc, sp, sf);
            chk($sformatf("vec%0d_pass", i), sp, vecs[i].exp_pass);
            chk($sformatf("vec%0d_fail", i), sf, !vecs[i].exp_pass);
            chk($sformatf("vec%0d_cycle", i), cyc, vecs[i].exp_cyc);
            chk($sformatf("vec%0d_fail_to", i), fail_timeout, vecs[i].exp_to);
            chk($sformatf("vec%0d_got", i), got_value, vecs[i].exp_got);
            chk($sformatf("vec%0d_wait", i), wait_cycles, vecs[i].exp_to ? 9 : 0);
            tick();
            chk($sformatf("vec%0d_pulse_len", i), pass_pulse, 0);
            chk($sformatf("vec%0d_all", i), all_passed, vecs[i].exp_pass);
            chk($sformatf("vec%0d_test_id", i), test_id, 1);
        end

        // Simple pass: reg2 becomes 4 from tick 3
        do_reset();
        rf_flat = '0;
        p0 = pulse_total;
        push(2, 16'h0004, 1'b1, ok);
        run_test(3, 2, 16'h0004, cyc, sp, sf);
        chk("simple_pass", sp, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("simple_pulses", pulse_total - p0, 1);
        chk("simple_all", all_passed, 1);
        chk("simple_test_id", test_id, 1);
        chk("simple_fail", fail, 0);
        chk("simple_got", got_value, 16'h0004);

        // Match in the final (10th) WAIT cycle wins over timeout
        do_reset();
        rf_flat = '0;
        push(0, 16'h55AA, 1'b1, ok);
        run_test(11, 0, 16'h55AA, cyc, sp, sf);
        chk("last_cycle_pass", sp, 1);
        chk("last_cycle_time", cyc, 12);
        chk("last_cycle_wait", wait_cycles, 9);
        tick();
        chk("last_cycle_nofail", fail, 0);

        // en_in pause freezes wait_cycles
        do_reset();
        rf_flat = '0;
        push(0, 16'h0F0F, 1'b1, ok);
        for (int i = 0; i < 7; i++) tick();
        chk("pause_pre", wait_cycles, 5);
        en_in = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("pause_frozen", wait_cycles, 5);
        chk("pause_nofail", fail, 0);
        en_in = 1'b1;
        tick();
        chk("pause_resume", wait_cycles, 6);
        run_test(0, 0, '0, cyc, sp, sf);
        chk("pause_fail", sf, 1);
        chk("pause_fail_to", fail_timeout, 1);
        chk("pause_wait", wait_cycles, 9);

        // Back-pressure: one test in flight plus QD queued fills the FIFO
        do_reset();
        rf_flat = '0;
        set_reg(1, 16'h1111);
        set_reg(2, 16'h2222);
        en_in = 1'b0;
        p0 = pulse_total;
        push(0, 16'hBEEF, 1'b0, ok);
        tick();
        tick();
        push(1, 16'h1111, 1'b0, ok);
        push(2, 16'h2222, 1'b0, ok);
        push(0, 16'hBEEF, 1'b0, ok);
        chk("bp_ready_before_full", exp_ready, 1);
        push(1, 16'h1111, 1'b0, ok);
        chk("bp_ready_full", exp_ready, 0);
        exp_valid = 1'b1; exp_reg = RW'(2); exp_value = 16'h2222; exp_last = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("bp_held", exp_ready, 0);
        chk("bp_no_pulse", pulse_total - p0, 0);
        set_reg(0, 16'hBEEF);
        en_in = 1'b1;
        push(2, 16'h2222, 1'b1, ok);
        chk("bp_accepted", ok, 1);
        for (int i = 0; i < 100 && !all_passed; i++) tick();
        chk("bp_all", all_passed, 1);
        chk("bp_pulses", pulse_total - p0, 6);
        chk("bp_test_id", test_id, 6);
        chk("bp_fail", fail, 0);

        // Reset mid-WAIT abandons the test
        do_reset();
        rf_flat = '0;
        set_reg(0, 16'h0005);
        push(0, 16'h0001, 1'b1, ok);
        for (int i = 0; i < 4; i++) tick();
        chk("midrst_pre_id", test_id, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", exp_ready, 1);
        chk("midrst_id", test_id, 0);
        chk("midrst_got", got_value, 0);
        chk("midrst_wait", wait_cycles, 0);
        chk("midrst_fail", fail, 0);
        p0 = pulse_total;
        tick();
        rst_n = 1'b1;
        set_reg(0, 16'h0001);
        for (int i = 0; i < 15; i++) tick();
        chk("midrst_no_pulse", pulse_total - p0, 0);
        chk("midrst_idle_id", test_id, 0);

`ifdef RF_CHK_MASK_EN
        // Masked compare: only the low byte matters
        do_reset();
        rf_flat = '0;
        set_reg(1, 16'hAB34);
        exp_mask = 16'h00FF;
        push(1, 16'h1234, 1'b1, ok);
        run_test(0, 0, '0, cyc, sp, sf);
        chk("mask_pass", sp, 1);
        do_reset();
        set_reg(1, 16'h1235);
        exp_mask = 16'h00FF;
        push(1, 16'h1234, 1'b1, ok);
        run_test(0, 0, '0, cyc, sp, sf);
        chk("mask_fail", sf, 1);
`endif

        // Randomised single checks against the rule-level model
        for (int n = 0; n < 20; n++) begin
            do_reset();
            r  = $urandom_range(0, 3);
            v  = DW'($urandom);
            k  = $urandom_range(1, 14);
            bg = v ^ (16'h0001 << $urandom_range(0, 15));
            for (int j = 0; j < NR; j++) set_reg(j, DW'($urandom));
            if (r < NR) set_reg(r, bg);
            if (r >= NR) begin
                exp_pass = 1'b0; exp_to = 1'b0; exp_got = '0; exp_cyc = 3; exp_wc = 0;
            end else if (k <= TO) begin
                exp_pass = 1'b1; exp_to = 1'b0; exp_got = v; exp_cyc = 2 + k; exp_wc = k - 1;
            end else begin
                exp_pass = 1'b0; exp_to = 1'b1; exp_got = bg; exp_cyc = 2 + TO; exp_wc = TO - 1;
            end
            push(r, v, 1'b1, ok);
            run_test(1 + k, r, v, cyc, sp, sf);
            chk($sformatf("rnd%0d_pass", n), sp, exp_pass);
            chk($sformatf("rnd%0d_cycle", n), cyc, exp_cyc);
            chk($sformatf("rnd%0d_fail_to", n), fail_timeout, exp_to);
            chk($sformatf("rnd%0d_got", n), got_value, exp_got);
            chk($sformatf("rnd%0d_wait", n), wait_cycles, exp_wc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
